// File: rtl/demux1x4_pkg.sv
// demux1x4_pkg.sv - shared constants and select type for the 1-to-4 demux slice.
package demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_pkg

// File: rtl/demux1x4_if.sv
// demux1x4_if.sv - data/select/lane bundle between a single source and the demux.
// master drives i and s and observes y; slave (the demux) does the reverse.
interface demux1x4_if
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) ();

  logic [DATA_W-1:0]           i;
  sel_t                        s;
  logic [NUM_LANES*DATA_W-1:0] y;

  modport master (output i, output s, input y);
  modport slave  (input i, input s, output y);

endinterface : demux1x4_if

// File: rtl/demux1x4_chk.sv
// demux1x4_chk.sv - simulation-only checker, compiled only with DEMUX1X4_ONEHOT_CHECK_EN.
// Flags any cycle where more than one lane is nonzero, and any nonzero y right
// after a reset edge.
`ifdef DEMUX1X4_ONEHOT_CHECK_EN
module demux_onehot_chk
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic                        clk,
  input logic                        rst,
  input logic [NUM_LANES*DATA_W-1:0] y
);

  function automatic int unsigned active_lanes(input logic [NUM_LANES*DATA_W-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (|v[k*DATA_W +: DATA_W]) n = n + 32'd1;
    end
    return n;
  endfunction

  logic rst_q_r;
  logic started_r;

  // Remember whether the most recent edge was a reset edge.
  always_ff @(posedge clk) begin
    rst_q_r   <= rst;
    started_r <= 1'b1;
  end

  // Check the settled outputs midway between edges.
  always @(negedge clk) begin
    if (started_r === 1'b1) begin
      assert (active_lanes(y) <= 32'd1)
        else $error("demux1x4: more than one active lane, y=%h at %0t", y, $time);
      if (rst_q_r === 1'b1) begin
        assert (y == {(NUM_LANES*DATA_W){1'b0}})
          else $error("demux1x4: y=%h nonzero after reset edge at %0t", y, $time);
      end
    end
  end

endmodule : demux_onehot_chk
`endif

// File: rtl/demux1x4_decode.sv
// demux1x4_decode.sv - combinational 2-to-4 one-hot decoder, select to lane enable.
module demux_decode
  import demux_pkg::*;
(
  input  sel_t                 sel,
  output logic [NUM_LANES-1:0] lane_en
);

  // Map the unsigned select index to a single lane enable bit.
  always_comb begin
    lane_en = 4'b0000;
    case (sel)
      2'd0:    lane_en = 4'b0001;
      2'd1:    lane_en = 4'b0010;
      2'd2:    lane_en = 4'b0100;
      2'd3:    lane_en = 4'b1000;
      default: lane_en = 4'b0000;
    endcase
  end

endmodule : demux_decode

// File: rtl/demux1x4.sv
// demux1x4.sv - registered 1-to-4 demultiplexer.
// Lane s of y takes i one clock after sampling; other lanes are zero.
// Optional build macro: DEMUX1X4_ONEHOT_CHECK_EN adds a simulation-only checker.
module demux1x4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic       clk,
  input  logic       rst,
  demux1x4_if.slave  bus
);

  logic [NUM_LANES-1:0]        lane_en_s;
  logic [NUM_LANES*DATA_W-1:0] y_next_s;
  logic [NUM_LANES*DATA_W-1:0] y_r;

  demux_decode u_decode (
    .sel     (bus.s),
    .lane_en (lane_en_s)
  );

  // Gate the data word into the enabled lane; all others stay zero.
  always_comb begin
    y_next_s = {(NUM_LANES*DATA_W){1'b0}};
    for (int k = 0; k < NUM_LANES; k++) begin
      y_next_s[k*DATA_W +: DATA_W] = bus.i & {DATA_W{lane_en_s[k]}};
    end
  end

  // Register every lane so consumers see a clean flop output; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= {(NUM_LANES*DATA_W){1'b0}};
    end else begin
      y_r <= y_next_s;
    end
  end

  assign bus.y = y_r;

`ifdef DEMUX1X4_ONEHOT_CHECK_EN
  demux_onehot_chk #(.DATA_W(DATA_W)) u_chk (
    .clk (clk),
    .rst (rst),
    .y   (y_r)
  );
`endif

endmodule : demux1x4

// File: tb/tb_demux1x4.sv
// tb_demux1x4.sv - self-checking bench for demux1x4 (DATA_W=1 and DATA_W=8 instances).
module tb_demux1x4;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] exp1_r;
  logic [31:0] exp8_r;
  logic        valid_r = 1'b0;

  always #5 clk = ~clk;

  demux1x4_if #(.DATA_W(1)) bus1 ();
  demux1x4_if #(.DATA_W(8)) bus8 ();

  demux1x4 #(.DATA_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  demux1x4 #(.DATA_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Reference: reset gives zero, otherwise the masked data word shifted to lane s.
  function automatic logic [31:0] model(input logic r, input logic [7:0] d,
                                        input logic [1:0] sel, input int w);
    logic [31:0] mask;
    if (r) return 32'd0;
    mask = (32'd1 << w) - 32'd1;
    return ({24'd0, d} & mask) << (int'(sel) * w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    exp1_r  <= model(rst, {7'd0, bus1.i}, bus1.s, 1);
    exp8_r  <= model(rst, bus8.i, bus8.s, 8);
    valid_r <= 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (valid_r) begin
      check("y1_model", {28'd0, bus1.y}, exp1_r);
      check("y8_model", bus8.y, exp8_r);
      check("y1_onehot", {31'd0, ($countones(bus1.y) > 1)}, 32'd0);
    end
  end

  task automatic apply(input logic r, input logic d, input logic [1:0] sel);
    @(negedge clk);
    rst    = r;
    bus1.i = d;
    bus1.s = sel;
    @(posedge clk);
    #1;
  endtask

  logic       sw_i [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] sw_s [8] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
  logic [3:0] sw_y [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0100,
                           4'b0000, 4'b0010, 4'b0000, 4'b1000};

  initial begin
    rst    = 1'b1;
    bus1.i = 1'b0;
    bus1.s = 2'd0;
    bus8.i = 8'hA5;
    bus8.s = 2'd2;

    // Reset holds y at zero even with live data; release loads lane 3.
    apply(1'b1, 1'b1, 2'd3);
    check("reset_y", {28'd0, bus1.y}, 32'h0000_0000);
    check("reset_y8", bus8.y, 32'h0000_0000);
    apply(1'b0, 1'b1, 2'd3);
    check("release_y", {28'd0, bus1.y}, 32'h0000_0008);

    // Full select/data sweep.
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, sw_i[k], sw_s[k]);
      check($sformatf("sweep%0d", k), {28'd0, bus1.y}, {28'd0, sw_y[k]});
    end

    // Back-to-back select change.
    apply(1'b0, 1'b1, 2'd0);
    check("b2b_s0", {28'd0, bus1.y}, 32'h0000_0001);
    apply(1'b0, 1'b1, 2'd3);
    check("b2b_s3", {28'd0, bus1.y}, 32'h0000_0008);

    // Reset in the middle of a running stream.
    apply(1'b0, 1'b1, 2'd2);
    check("mid_run", {28'd0, bus1.y}, 32'h0000_0004);
    apply(1'b1, 1'b1, 2'd2);
    check("mid_rst", {28'd0, bus1.y}, 32'h0000_0000);
    apply(1'b0, 1'b1, 2'd2);
    check("mid_resume", {28'd0, bus1.y}, 32'h0000_0004);

    // Wide lanes: A5 lands in lane 2 only.
    check("w8_lane2", bus8.y, 32'h00A5_0000);

    // Randomized run with occasional resets on both instances.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 15) == 0);
      bus1.i = 1'($urandom_range(0, 1));
      bus1.s = 2'($urandom_range(0, 3));
      bus8.i = 8'($urandom_range(0, 255));
      bus8.s = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_demux1x4
